fir_mac_seq: RTL and testbench

- Sequential multiply-accumulate FIR stage that sits directly upstream of the 21-bit enable-controlled output register.
- Accepts one signed sample per handshake and shifts it into a TAPS-deep delay line.
- Computes one MAC per cycle against coefficients read from an external asynchronous ROM.
- Emits a 21-bit result with a one-cycle OutputValid strobe that drives the output register's enable.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_sat_conv.sv | 41 ++++
 rtl/fir_mac_seq.sv | 116 +++++++++++
 tb/tb_fir_mac_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults, derived widths, state type and saturation bounds for fir_mac_seq
package fir_pkg;

    localparam int TAPS_DEF = 8;
    localparam int DW_DEF   = 12;
    localparam int CW_DEF   = 8;
    localparam int OW_DEF   = 21;

    localparam int AAW_DEF  = $clog2(TAPS_DEF);
    // Full-precision product plus log2(TAPS) guard bits: the sum of TAPS products cannot overflow.
    localparam int AW_DEF   = DW_DEF + CW_DEF + AAW_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } fir_state_e;

    function automatic int sat_hi(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int ow);
        return -(1 << (ow - 1));
    endfunction

    localparam int SAT_HI_DEF = sat_hi(OW_DEF);
    localparam int SAT_LO_DEF = sat_lo(OW_DEF);

endpackage

// File: rtl/fir_sat_conv.sv
// rtl/fir_sat_conv.sv - combinational AW-to-OW conversion, saturating when FIR_MAC_SAT_EN is defined, wrapping otherwise
//
// Ports:
//   sum    in  AW  signed accumulator result
//   result out OW  signed converted result
//   clip   out 1   result was clipped (only with FIR_MAC_SAT_EN)
module fir_sat_conv
    import fir_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic signed [AW-1:0] sum,
    output logic signed [OW-1:0] result
`ifdef FIR_MAC_SAT_EN
    ,
    output logic                 clip
`endif
);

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [AW-1:0] HI = AW'(sat_hi(OW));
    localparam logic signed [AW-1:0] LO = AW'(sat_lo(OW));

    always_comb begin
        result = OW'(sum);
        clip   = 1'b0;
        if (sum > HI) begin
            result = OW'(HI);
            clip   = 1'b1;
        end else if (sum < LO) begin
            result = OW'(LO);
            clip   = 1'b1;
        end
    end
`else
    // Wrap: keep the low OW bits, modulo 2^OW.
    assign result = OW'(sum);
`endif

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential one-MAC-per-cycle FIR stage (optional saturation via FIR_MAC_SAT_EN)
//
// Ports:
//   clk          in   system clock, posedge
//   GlobalReset  in   synchronous active-high reset
//   InputValid   in   sample strobe, taken only while Busy=0
//   InputSample  in   DW signed sample
//   CoefAddr     out  registered coefficient ROM address
//   CoefData     in   CW signed coefficient from async ROM
//   Busy         out  MAC sequence in progress
//   OutputValid  out  one-cycle result strobe
//   OutputData   out  OW signed result, held between strobes
//   SatFlag      out  sticky clip indicator (only with FIR_MAC_SAT_EN)
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int OW   = OW_DEF
) (
    input  logic                      clk,
    input  logic                      GlobalReset,
    input  logic                      InputValid,
    input  logic signed [DW-1:0]      InputSample,
    output logic [$clog2(TAPS)-1:0]   CoefAddr,
    input  logic signed [CW-1:0]      CoefData,
    output logic                      Busy,
    output logic                      OutputValid,
    output logic signed [OW-1:0]      OutputData
`ifdef FIR_MAC_SAT_EN
    ,
    output logic                      SatFlag
`endif
);

    localparam int AAW = $clog2(TAPS);
    localparam int PW  = DW + CW;
    localparam int AW  = PW + AAW;

    fir_state_e              state, state_next;
    logic signed [DW-1:0]    dline [TAPS];
    logic signed [AW-1:0]    acc;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    sum;
    logic signed [OW-1:0]    conv_out;
    logic                    accept;
    logic                    last_step;
`ifdef FIR_MAC_SAT_EN
    logic                    clip;
`endif

    // Operands are sign-extended to the product width before multiplying so
    // the product is full precision.
    assign prod      = PW'(dline[CoefAddr]) * PW'(CoefData);
    assign sum       = acc + AW'(prod);
    assign accept    = (state == IDLE) && InputValid;
    assign last_step = (state == MAC) && (CoefAddr == AAW'(TAPS - 1));
    assign Busy      = (state == MAC);

    fir_sat_conv #(
        .AW (AW),
        .OW (OW)
    ) u_conv (
        .sum    (sum),
        .result (conv_out)
`ifdef FIR_MAC_SAT_EN
        ,
        .clip   (clip)
`endif
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (InputValid) state_next = MAC;
            MAC:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state       <= IDLE;
            acc         <= '0;
            CoefAddr    <= '0;
            OutputData  <= '0;
            OutputValid <= 1'b0;
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
`ifdef FIR_MAC_SAT_EN
            SatFlag     <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            OutputValid <= 1'b0;
            if (accept) begin
                dline[0] <= InputSample;
                for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
                acc      <= '0;
                CoefAddr <= '0;
            end else if (state == MAC) begin
                acc      <= sum;
                // Wraps to 0 after the last tap because TAPS is a power of two.
                CoefAddr <= CoefAddr + AAW'(1);
                if (last_step) begin
                    OutputData  <= conv_out;
                    OutputValid <= 1'b1;
`ifdef FIR_MAC_SAT_EN
                    SatFlag     <= SatFlag | clip;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - self-checking bench for fir_mac_seq against a behavioural FIR model
module tb_fir_mac_seq;

    localparam int TAPS = 8;
    localparam int DW   = 12;
    localparam int CW   = 8;
    localparam int OW   = 21;
    localparam int AAW  = 3;

    logic                   clk = 1'b0;
    logic                   GlobalReset;
    logic                   InputValid;
    logic signed [DW-1:0]   InputSample;
    logic [AAW-1:0]         CoefAddr;
    logic signed [CW-1:0]   CoefData;
    logic                   Busy;
    logic                   OutputValid;
    logic signed [OW-1:0]   OutputData;
`ifdef FIR_MAC_SAT_EN
    logic                   SatFlag;
`endif

    logic signed [CW-1:0]   rom [TAPS];
    int                     hist [TAPS];
    bit                     sat_model;
    int                     vectors = 0;
    int                     errors  = 0;

    always #5 clk = ~clk;

    assign CoefData = rom[CoefAddr];

    fir_mac_seq #(
        .TAPS (TAPS),
        .DW   (DW),
        .CW   (CW),
        .OW   (OW)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .InputValid  (InputValid),
        .InputSample (InputSample),
        .CoefAddr    (CoefAddr),
        .CoefData    (CoefData),
        .Busy        (Busy),
        .OutputValid (OutputValid),
        .OutputData  (OutputData)
`ifdef FIR_MAC_SAT_EN
        ,
        .SatFlag     (SatFlag)
`endif
    );

    // Reference: y = sum over k of x[n-k] * c[k], then convert to OW bits.
    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(rom[k]);
        return s;
    endfunction

    function automatic logic signed [OW-1:0] model_conv(input longint v);
        longint hi = (64'sd1 <<< (OW - 1)) - 1;
        longint lo = -(64'sd1 <<< (OW - 1));
        longint w  = v;
`ifdef FIR_MAC_SAT_EN
        if (v > hi) w = hi;
        if (v < lo) w = lo;
`endif
        return w[OW-1:0];
    endfunction

    function automatic bit model_clips(input longint v);
        return (v > ((64'sd1 <<< (OW - 1)) - 1)) || (v < -(64'sd1 <<< (OW - 1)));
    endfunction

    task automatic push(input int s);
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        InputValid  = 1'b0;
        InputSample = '0;
        GlobalReset = 1'b1;
        step();
        step();
        GlobalReset = 1'b0;
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        sat_model = 1'b0;
    endtask

    // Offers one sample from IDLE, waits (bounded) for its result, then checks the pulse width.
    task automatic run_sample(input int s, output logic signed [OW-1:0] data,
                              output int lat, output bit single);
        InputSample = DW'(s);
        InputValid  = 1'b1;
        step();
        InputValid  = 1'b0;
        InputSample = '0;
        push(s);
        lat = 1;
        while (OutputValid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        data = OutputData;
        step();
        single = (OutputValid === 1'b0);
    endtask

    task automatic test_reset();
        InputValid  = 1'b1;
        InputSample = 12'sd77;
        GlobalReset = 1'b1;
        step();
        step();
        InputValid  = 1'b0;
        GlobalReset = 1'b0;
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        sat_model = 1'b0;
        vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", Busy); end
        vectors++;
        if (OutputValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", OutputValid); end
        vectors++;
        if (OutputData !== '0) begin errors++; $display("FAIL reset_data got=%0d want=0", OutputData); end
        vectors++;
        if (CoefAddr !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", CoefAddr); end
`ifdef FIR_MAC_SAT_EN
        vectors++;
        if (SatFlag !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b want=0", SatFlag); end
`endif
    endtask

    task automatic test_impulse();
        logic signed [OW-1:0] d;
        int lat;
        bit single;
        do_reset();
        for (int k = 0; k < TAPS; k++) rom[k] = CW'(k + 1);
        for (int i = 0; i < TAPS; i++) begin
            run_sample((i == 0) ? 1 : 0, d, lat, single);
            vectors++;
            if (d !== OW'(i + 1)) begin errors++; $display("FAIL impulse_data[%0d] got=%0d want=%0d", i, d, i + 1); end
            vectors++;
            if (lat != TAPS + 1) begin errors++; $display("FAIL impulse_latency[%0d] got=%0d want=%0d", i, lat, TAPS + 1); end
            vectors++;
            if (!single) begin errors++; $display("FAIL impulse_pulse_width[%0d] got=wide want=single", i); end
        end
    endtask

    task automatic test_extremes();
        logic signed [OW-1:0] d;
        int lat;
        bit single;
        do_reset();
        for (int k = 0; k < TAPS; k++) rom[k] = -8'sd128;
        for (int i = 0; i < TAPS; i++) begin
            run_sample(-2048, d, lat, single);
            sat_model |= model_clips(model_sum());
            vectors++;
            if (d !== model_conv(model_sum()))
                begin errors++; $display("FAIL extreme_data[%0d] got=%0d want=%0d", i, d, model_conv(model_sum())); end
        end
`ifdef FIR_MAC_SAT_EN
        vectors++;
        if (d !== 21'sd1048575) begin errors++; $display("FAIL extreme_sat_final got=%0d want=1048575", d); end
        vectors++;
        if (SatFlag !== 1'b1) begin errors++; $display("FAIL extreme_satflag got=%b want=1", SatFlag); end
`else
        vectors++;
        if (d !== '0) begin errors++; $display("FAIL extreme_wrap_final got=%0d want=0", d); end
`endif
    endtask

    task automatic test_drop_busy();
        logic signed [OW-1:0] d;
        int lat;
        bit single;
        do_reset();
        for (int k = 0; k < TAPS; k++) rom[k] = CW'(k + 1);
        InputSample = 12'sd100;
        InputValid  = 1'b1;
        step();
        InputValid  = 1'b0;
        push(100);
        step();
        InputSample = 12'sd555;
        InputValid  = 1'b1;
        step();
        InputValid  = 1'b0;
        lat = 3;
        while (OutputValid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        d = OutputData;
        step();
        vectors++;
        if (lat != TAPS + 1) begin errors++; $display("FAIL drop_latency got=%0d want=%0d", lat, TAPS + 1); end
        vectors++;
        if (d !== 21'sd100) begin errors++; $display("FAIL drop_first got=%0d want=100", d); end
        run_sample(0, d, lat, single);
        vectors++;
        if (d !== 21'sd200 || d !== model_conv(model_sum()))
            begin errors++; $display("FAIL drop_second got=%0d want=200", d); end
    endtask

    task automatic test_back_to_back();
        int smp [5*(TAPS+1)];
        int pulses = 0;
        logic signed [OW-1:0] expv = '0;
        do_reset();
        for (int k = 0; k < TAPS; k++) rom[k] = CW'($urandom_range(0, 255));
        InputValid = 1'b1;
        for (int c = 0; c < 5 * (TAPS + 1); c++) begin
            smp[c]      = int'($urandom_range(0, 4095)) - 2048;
            InputSample = DW'(smp[c]);
            if (c % (TAPS + 1) == 0) begin
                push(smp[c]);
                expv = model_conv(model_sum());
            end
            step();
            if (OutputValid === 1'b1) begin
                pulses++;
                vectors++;
                if (c % (TAPS + 1) != TAPS)
                    begin errors++; $display("FAIL b2b_timing got=cycle%0d want=cycle%%%0d==%0d", c, TAPS + 1, TAPS); end
                vectors++;
                if (OutputData !== expv)
                    begin errors++; $display("FAIL b2b_data got=%0d want=%0d", OutputData, expv); end
            end
        end
        InputValid = 1'b0;
        vectors++;
        if (pulses != 5) begin errors++; $display("FAIL b2b_count got=%0d want=5", pulses); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [OW-1:0] d;
        int lat;
        bit single;
        int seen = 0;
        do_reset();
        for (int k = 0; k < TAPS; k++) rom[k] = CW'(k + 1);
        run_sample(7, d, lat, single);
        InputSample = 12'sd5;
        InputValid  = 1'b1;
        step();
        InputValid  = 1'b0;
        step();
        step();
        step();
        vectors++;
        if (CoefAddr !== 3'd3) begin errors++; $display("FAIL midrst_step got=%0d want=3", CoefAddr); end
        GlobalReset = 1'b1;
        step();
        GlobalReset = 1'b0;
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", Busy); end
        vectors++;
        if (OutputData !== '0) begin errors++; $display("FAIL midrst_data got=%0d want=0", OutputData); end
        for (int i = 0; i < 12; i++) begin
            if (OutputValid === 1'b1) seen++;
            step();
        end
        vectors++;
        if (seen != 0) begin errors++; $display("FAIL midrst_novalid got=%0d want=0", seen); end
        run_sample(1, d, lat, single);
        vectors++;
        if (d !== 21'sd1) begin errors++; $display("FAIL midrst_clean1 got=%0d want=1", d); end
        run_sample(0, d, lat, single);
        vectors++;
        if (d !== 21'sd2) begin errors++; $display("FAIL midrst_clean2 got=%0d want=2", d); end
    endtask

    task automatic test_coef_addr();
        do_reset();
        vectors++;
        if (CoefAddr !== '0) begin errors++; $display("FAIL addr_idle got=%0d want=0", CoefAddr); end
        InputSample = 12'sd3;
        InputValid  = 1'b1;
        step();
        InputValid  = 1'b0;
        push(3);
        for (int k = 0; k < TAPS; k++) begin
            vectors++;
            if (CoefAddr !== AAW'(k) || Busy !== 1'b1)
                begin errors++; $display("FAIL addr_trace[%0d] got=%0d busy=%b want=%0d busy=1", k, CoefAddr, Busy, k); end
            step();
        end
        vectors++;
        if (OutputValid !== 1'b1 || Busy !== 1'b0 || OutputData !== model_conv(model_sum()))
            begin errors++; $display("FAIL addr_end got=v%b b%b d%0d want=v1 b0 d%0d", OutputValid, Busy, OutputData, model_conv(model_sum())); end
        step();
    endtask

    task automatic test_random();
        logic signed [OW-1:0] d;
        int lat;
        bit single;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < TAPS; k++) rom[k] = CW'($urandom_range(0, 255));
            for (int i = 0; i < 6; i++) begin
                run_sample(int'($urandom_range(0, 4095)) - 2048, d, lat, single);
                sat_model |= model_clips(model_sum());
                vectors++;
                if (d !== model_conv(model_sum()) || lat != TAPS + 1 || !single)
                    begin errors++; $display("FAIL random[%0d.%0d] got=%0d lat=%0d want=%0d lat=%0d", r, i, d, lat, model_conv(model_sum()), TAPS + 1); end
`ifdef FIR_MAC_SAT_EN
                vectors++;
                if (SatFlag !== sat_model) begin errors++; $display("FAIL random_sat got=%b want=%b", SatFlag, sat_model); end
`endif
            end
        end
    endtask

    initial begin
        GlobalReset = 1'b1;
        InputValid  = 1'b0;
        InputSample = '0;
        for (int k = 0; k < TAPS; k++) rom[k] = '0;
        test_reset();
        test_impulse();
        test_extremes();
        test_drop_busy();
        test_back_to_back();
        test_reset_mid_mac();
        test_coef_addr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
